// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative RV32M multiply/divide unit that stalls the PC until its result retires
// Ports: clk/rst (async, active-high); start_i, op_i (funct3), rs1_rdata_i, rs2_rdata_i, rd_waddr_i
//        issue one M-type operation; flush_i aborts it; busy_o = not idle; hold_o = PC stall;
//        valid_o pulses with rd_waddr_o/rd_wdata_o for one cycle (both zero otherwise).
// Optional: define MULDIV_FAST_MUL_EN for single-cycle multiplies via a combinational multiplier.
module exu_muldiv #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   rs1_rdata_i,
  input  logic [XLEN-1:0]   rs2_rdata_i,
  input  logic [REG_AW-1:0] rd_waddr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              hold_o,
  output logic              valid_o,
  output logic [REG_AW-1:0] rd_waddr_o,
  output logic [XLEN-1:0]   rd_wdata_o
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_nx, prod;
  logic [REG_AW-1:0] rd_q, rd_d, waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              s1, s2, neg1, neg2, special, fast, div_ge;
  logic [XLEN-1:0]   mag1, mag2, spec_res, fast_res, res, quo, rem, div_diff;
  logic [XLEN:0]     mul_sum, div_sh;
  assign s2   = op_i == 3'd1 || (op_i[2] && !op_i[0]);
  assign s1   = s2 || op_i == 3'd2;
  assign neg1 = s1 & rs1_rdata_i[XLEN-1];
  assign neg2 = s2 & rs2_rdata_i[XLEN-1];
  assign mag1 = neg1 ? -rs1_rdata_i : rs1_rdata_i;
  assign mag2 = neg2 ? -rs2_rdata_i : rs2_rdata_i;
  // divide by zero and most-negative / -1 are answered without iterating
  assign special = op_i[2] & (rs2_rdata_i == '0 |
                   (!op_i[0] & rs1_rdata_i == {1'b1, {(XLEN-1){1'b0}}} & &rs2_rdata_i));
  assign spec_res = rs2_rdata_i == '0 ? (op_i[1] ? rs1_rdata_i : '1) : (op_i[1] ? '0 : rs1_rdata_i);
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod;
  // sign-extending both operands to 2*XLEN makes one unsigned multiply serve every signedness
  assign fprod    = {{XLEN{neg1}}, rs1_rdata_i} * {{XLEN{neg2}}, rs2_rdata_i};
  assign fast     = !op_i[2];
  assign fast_res = op_i[1:0] == 2'd0 ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif
  // acc holds {partial high, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge   = div_sh >= {1'b0, m_q};
  assign div_diff = div_sh[XLEN-1:0] - m_q;
  assign acc_nx   = op_q[2] ? {div_ge ? div_diff : div_sh[XLEN-1:0], acc_q[XLEN-2:0], div_ge}
                            : {mul_sum, acc_q[XLEN-1:1]};
  assign prod     = (sa_q ^ sb_q) ? -acc_nx : acc_nx;
  assign quo      = (sa_q ^ sb_q) ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
  assign rem      = sa_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
  assign res      = op_q[2] ? (op_q[1] ? rem : quo)
                            : (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    m_d     = m_q;
    acc_d   = acc_q;
    rd_d    = rd_q;
    waddr_d = '0;
    wdata_d = '0;
    if (flush_i) state_d = IDLE;
    else if (state_q == IDLE && start_i) begin
      op_d = op_i;
      sa_d = neg1;
      sb_d = neg2;
      rd_d = rd_waddr_i;
      if (special || fast) begin
        state_d = DONE;
        waddr_d = rd_waddr_i;
        wdata_d = special ? spec_res : fast_res;
      end else begin
        state_d = CALC;
        cnt_d   = CW'(XLEN-1);
        m_d     = op_i[2] ? mag2 : mag1;
        acc_d   = {{XLEN{1'b0}}, op_i[2] ? mag1 : mag2};
      end
    end else if (state_q == CALC) begin
      acc_d = acc_nx;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = DONE;
        waddr_d = rd_q;
        wdata_d = res;
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      rd_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      rd_q    <= rd_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign busy_o     = state_q != IDLE;
  assign hold_o     = (state_q == IDLE && start_i && !flush_i) || state_q == CALC;
  assign valid_o    = state_q == DONE;
  assign rd_waddr_o = waddr_q;
  assign rd_wdata_o = wdata_q;
endmodule
